vram_arbiter: RTL and testbench

- Shares the single framebuffer access port (sel/wr/mask/address/data/ack) among NUM_REQ requesters, e.g. the test pattern generator, a CPU bridge and a rasterizer.
- Grants round-robin, latches one command per grant, presents it to the framebuffer until ack, then returns ack and read data to the granted requester.
- Includes an ack watchdog so a hung framebuffer cannot stall all requesters.

---
 rtl/vram_arbiter_pkg.sv | 21 ++
 rtl/vram_arbiter_if.sv | 24 ++
 rtl/vram_arbiter_rr_pick.sv | 33 +++
 rtl/vram_arbiter.sv | 148 ++++++++++++++
 tb/tb_vram_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types and default widths for the framebuffer port arbiter.
package vram_arb_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [MASK_W-1:0] mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Framebuffer access port: the arbiter is the master, the framebuffer the slave.
interface vram_arbiter_if #(
  parameter int ADDR_W = vram_arb_pkg::ADDR_W,
  parameter int DATA_W = vram_arb_pkg::DATA_W,
  parameter int MASK_W = vram_arb_pkg::MASK_W
);
  logic              fb_sel_o;
  logic              fb_wr_o;
  logic [MASK_W-1:0] fb_mask_o;
  logic [ADDR_W-1:0] fb_address_o;
  logic [DATA_W-1:0] fb_data_o;
  logic              fb_ack_i;
  logic [DATA_W-1:0] fb_data_i;

  modport master (
    output fb_sel_o, fb_wr_o, fb_mask_o, fb_address_o, fb_data_o,
    input  fb_ack_i, fb_data_i
  );

  modport slave (
    input  fb_sel_o, fb_wr_o, fb_mask_o, fb_address_o, fb_data_o,
    output fb_ack_i, fb_data_i
  );
endinterface

// File: rtl/vram_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         winner,
  output logic [$clog2(NUM_REQ)-1:0] index,
  output logic                       valid
);
  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    // Upper segment [ptr..N-1] has priority over the wrapped segment [0..ptr-1].
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (IDX_W'(i) >= ptr)) begin
        valid     = 1'b1;
        winner[i] = 1'b1;
        index     = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (IDX_W'(i) < ptr)) begin
        valid     = 1'b1;
        winner[i] = 1'b1;
        index     = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Round-robin arbiter sharing one framebuffer port among NUM_REQ requesters,
// with an ack watchdog that aborts a transaction the framebuffer never completes.
//
// state   | meaning
// IDLE    | no transaction; pick a requester if any is asking
// ISSUE   | latched command on the framebuffer, waiting for ack or watchdog
// RELEASE | one cycle of ack/err to the requester, then back to IDLE
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = vram_arb_pkg::ADDR_W,
  parameter int DATA_W         = vram_arb_pkg::DATA_W,
  parameter int MASK_W         = vram_arb_pkg::MASK_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset_ni,
  input  logic [NUM_REQ-1:0]        req_sel_i,
  input  logic [NUM_REQ-1:0]        req_wr_i,
  input  logic [NUM_REQ*MASK_W-1:0] req_mask_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic                      req_err_o,
  output logic [DATA_W-1:0]         req_data_o,
  vram_arbiter_if.master            fb,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      timeout_o
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic              wr;
    logic [MASK_W-1:0] mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fb_cmd_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   rr_ptr, owner;
  logic [WD_W-1:0]    wd, wd_inc;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  fb_cmd_t            pick_cmd;
  logic               start, finish, abort;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req_sel_i),
    .ptr    (rr_ptr),
    .winner (pick_onehot),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  assign wd_inc = wd + 1'b1;

  always_comb begin
    pick_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        pick_cmd.wr   = req_wr_i[i];
        pick_cmd.mask = req_mask_i[i*MASK_W +: MASK_W];
        pick_cmd.addr = req_addr_i[i*ADDR_W +: ADDR_W];
        pick_cmd.data = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          start      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (fb.fb_ack_i) begin
          finish     = 1'b1;
          state_next = RELEASE;
        end else if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
          finish     = 1'b1;
          abort      = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      wd              <= '0;
      grant_o         <= '0;
      req_ack_o       <= '0;
      req_err_o       <= 1'b0;
      req_data_o      <= '0;
      timeout_o       <= 1'b0;
      fb.fb_sel_o     <= 1'b0;
      fb.fb_wr_o      <= 1'b0;
      fb.fb_mask_o    <= '0;
      fb.fb_address_o <= '0;
      fb.fb_data_o    <= '0;
    end else begin
      state     <= state_next;
      req_ack_o <= '0;
      req_err_o <= 1'b0;
      if (start) begin
        fb.fb_sel_o     <= 1'b1;
        fb.fb_wr_o      <= pick_cmd.wr;
        fb.fb_mask_o    <= pick_cmd.mask;
        fb.fb_address_o <= pick_cmd.addr;
        fb.fb_data_o    <= pick_cmd.data;
        grant_o         <= pick_onehot;
        owner           <= pick_idx;
        wd              <= '0;
      end
      if (state == ISSUE && !finish) begin
        wd <= wd_inc;
      end
      if (finish) begin
        fb.fb_sel_o <= 1'b0;
        req_ack_o   <= grant_o;
        req_err_o   <= abort;
        rr_ptr      <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        if (abort) begin
          timeout_o <= 1'b1;
        end else begin
          req_data_o <= fb.fb_data_i;
        end
      end
      if (state == RELEASE) begin
        grant_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: two requesters, 8-cycle watchdog.
module tb_vram_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 24;
  localparam int DW   = 16;
  localparam int MW   = 4;

  logic              clk;
  logic              reset_ni;
  logic [NREQ-1:0]   req_sel;
  logic [NREQ-1:0]   req_wr;
  logic [NREQ*MW-1:0] req_mask;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_ack;
  logic              req_err;
  logic [DW-1:0]     req_rdata;
  logic [NREQ-1:0]   grant;
  logic              timeout;

  int checks = 0;
  int errors = 0;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) fb ();

  vram_arbiter #(
    .NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset_ni   (reset_ni),
    .req_sel_i  (req_sel),
    .req_wr_i   (req_wr),
    .req_mask_i (req_mask),
    .req_addr_i (req_addr),
    .req_data_i (req_wdata),
    .req_ack_o  (req_ack),
    .req_err_o  (req_err),
    .req_data_o (req_rdata),
    .fb         (fb),
    .grant_o    (grant),
    .timeout_o  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_sel(input int budget, output bit seen);
    seen = fb.fb_sel_o;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = fb.fb_sel_o;
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (fb.fb_sel_o !== 1'b0) begin errors++; $display("FAIL reset_sel got %b want 0", fb.fb_sel_o); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
    checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", req_ack); end
    checks++; if (timeout !== 1'b0 || req_err !== 1'b0) begin errors++; $display("FAIL reset_flags got to=%b err=%b want 0 0", timeout, req_err); end
    checks++; if (fb.fb_address_o !== 24'h0 || req_rdata !== 16'h0) begin errors++; $display("FAIL reset_data got addr=%h data=%h want 0 0", fb.fb_address_o, req_rdata); end
    reset_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    bit seen;
    req_addr[0 +: AW] = 24'h000123;
    req_wr[0] = 1'b0;
    req_sel = 2'b01;
    wait_sel(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL read_sel_wait got no fb_sel want fb_sel within 10 cycles"); end
    checks++; if (fb.fb_address_o !== 24'h000123) begin errors++; $display("FAIL read_addr got %h want 000123", fb.fb_address_o); end
    checks++; if (fb.fb_wr_o !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL read_cmd got wr=%b grant=%b want 0 01", fb.fb_wr_o, grant); end
    repeat (4) @(negedge clk);
    checks++; if (fb.fb_sel_o !== 1'b1 || req_ack !== 2'b00) begin errors++; $display("FAIL read_hold got sel=%b ack=%b want 1 00", fb.fb_sel_o, req_ack); end
    fb.fb_ack_i = 1'b1; fb.fb_data_i = 16'hBEEF;
    @(negedge clk);
    fb.fb_ack_i = 1'b0; fb.fb_data_i = 16'h0; req_sel = 2'b00;
    checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL read_ack got %b want 01", req_ack); end
    checks++; if (req_rdata !== 16'hBEEF || req_err !== 1'b0) begin errors++; $display("FAIL read_data got %h err=%b want beef 0", req_rdata, req_err); end
    checks++; if (fb.fb_sel_o !== 1'b0) begin errors++; $display("FAIL read_sel_low1 got %b want 0", fb.fb_sel_o); end
    @(negedge clk);
    checks++; if (req_ack !== 2'b00 || fb.fb_sel_o !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL read_release got ack=%b sel=%b grant=%b want 00 0 00", req_ack, fb.fb_sel_o, grant); end
    checks++; if (req_rdata !== 16'hBEEF) begin errors++; $display("FAIL read_data_hold got %h want beef", req_rdata); end
  endtask

  task automatic test_contention();
    bit seen;
    logic [1:0]  exp;
    logic [23:0] exp_addr;
    reset_ni = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
    req_addr[0 +: AW] = 24'h000010;
    req_addr[AW +: AW] = 24'h000020;
    req_wr = 2'b00;
    req_sel = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 24'h000010 : 24'h000020;
      wait_sel(10, seen);
      checks++; if (!seen) begin errors++; $display("FAIL cont_sel_wait[%0d] got no fb_sel want fb_sel", i); end
      checks++; if (grant !== exp) begin errors++; $display("FAIL cont_grant[%0d] got %b want %b", i, grant, exp); end
      checks++; if (fb.fb_address_o !== exp_addr) begin errors++; $display("FAIL cont_addr[%0d] got %h want %h", i, fb.fb_address_o, exp_addr); end
      @(negedge clk);
      fb.fb_ack_i = 1'b1; fb.fb_data_i = 16'(i);
      @(negedge clk);
      fb.fb_ack_i = 1'b0;
      if (i == 3) req_sel = 2'b00;
      checks++; if (req_ack !== exp) begin errors++; $display("FAIL cont_ack[%0d] got %b want %b", i, req_ack, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_write_latch();
    bit seen;
    req_wr[1] = 1'b1;
    req_mask[MW +: MW] = 4'h3;
    req_wdata[DW +: DW] = 16'h0F0F;
    req_addr[AW +: AW] = 24'h00ABCD;
    req_sel = 2'b10;
    wait_sel(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL wr_sel_wait got no fb_sel want fb_sel"); end
    checks++; if (fb.fb_wr_o !== 1'b1 || grant !== 2'b10) begin errors++; $display("FAIL wr_cmd got wr=%b grant=%b want 1 10", fb.fb_wr_o, grant); end
    checks++; if (fb.fb_data_o !== 16'h0F0F || fb.fb_mask_o !== 4'h3) begin errors++; $display("FAIL wr_latch got data=%h mask=%h want 0f0f 3", fb.fb_data_o, fb.fb_mask_o); end
    req_wdata[DW +: DW] = 16'h1234;
    req_mask[MW +: MW] = 4'hF;
    req_wr[1] = 1'b0;
    req_sel = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (fb.fb_data_o !== 16'h0F0F || fb.fb_mask_o !== 4'h3 || fb.fb_wr_o !== 1'b1) begin errors++; $display("FAIL wr_hold got data=%h mask=%h wr=%b want 0f0f 3 1", fb.fb_data_o, fb.fb_mask_o, fb.fb_wr_o); end
    checks++; if (fb.fb_sel_o !== 1'b1) begin errors++; $display("FAIL wr_sel_hold got %b want 1", fb.fb_sel_o); end
    fb.fb_ack_i = 1'b1; fb.fb_data_i = 16'h5555;
    @(negedge clk);
    fb.fb_ack_i = 1'b0;
    checks++; if (req_ack !== 2'b10 || req_err !== 1'b0) begin errors++; $display("FAIL wr_ack got ack=%b err=%b want 10 0", req_ack, req_err); end
    checks++; if (req_rdata !== 16'h5555) begin errors++; $display("FAIL wr_rdata got %h want 5555", req_rdata); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit seen;
    int hi;
    req_addr[0 +: AW] = 24'h000777;
    req_wr = 2'b00;
    req_sel = 2'b01;
    wait_sel(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL to_sel_wait got no fb_sel want fb_sel"); end
    hi = 0;
    for (int n = 0; n < 20 && fb.fb_sel_o; n++) begin
      hi++;
      @(negedge clk);
    end
    req_sel = 2'b00;
    checks++; if (hi !== 8) begin errors++; $display("FAIL to_issue_len got %0d want 8", hi); end
    checks++; if (req_ack !== 2'b01 || req_err !== 1'b1) begin errors++; $display("FAIL to_abort got ack=%b err=%b want 01 1", req_ack, req_err); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky_set got %b want 1", timeout); end
    checks++; if (req_rdata !== 16'h5555) begin errors++; $display("FAIL to_rdata_keep got %h want 5555", req_rdata); end
    @(negedge clk);
    checks++; if (req_err !== 1'b0 || timeout !== 1'b1) begin errors++; $display("FAIL to_after got err=%b to=%b want 0 1", req_err, timeout); end
    req_addr[AW +: AW] = 24'h000999;
    req_sel = 2'b10;
    wait_sel(10, seen);
    checks++; if (!seen || grant !== 2'b10) begin errors++; $display("FAIL to_next_grant got sel=%b grant=%b want 1 10", seen, grant); end
    fb.fb_ack_i = 1'b1; fb.fb_data_i = 16'h1357;
    @(negedge clk);
    fb.fb_ack_i = 1'b0;
    req_sel = 2'b00;
    checks++; if (req_ack !== 2'b10 || req_err !== 1'b0 || req_rdata !== 16'h1357) begin errors++; $display("FAIL to_next_ack got ack=%b err=%b data=%h want 10 0 1357", req_ack, req_err, req_rdata); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky_keep got %b want 1", timeout); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_issue();
    bit seen;
    req_sel = 2'b01;
    wait_sel(10, seen);
    fb.fb_ack_i = 1'b1; fb.fb_data_i = 16'h2222;
    @(negedge clk);
    fb.fb_ack_i = 1'b0;
    req_sel = 2'b00;
    @(negedge clk);
    req_sel = 2'b10;
    wait_sel(10, seen);
    checks++; if (!seen || grant !== 2'b10) begin errors++; $display("FAIL rst_pre_grant got sel=%b grant=%b want 1 10", seen, grant); end
    reset_ni = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
    fb.fb_ack_i = 1'b1; fb.fb_data_i = 16'hDEAD;
    req_sel = 2'b00;
    checks++; if (fb.fb_sel_o !== 1'b0 || grant !== 2'b00 || req_ack !== 2'b00) begin errors++; $display("FAIL rst_outputs got sel=%b grant=%b ack=%b want 0 00 00", fb.fb_sel_o, grant, req_ack); end
    checks++; if (timeout !== 1'b0 || req_rdata !== 16'h0) begin errors++; $display("FAIL rst_flags got to=%b data=%h want 0 0000", timeout, req_rdata); end
    @(negedge clk);
    fb.fb_ack_i = 1'b0;
    checks++; if (req_ack !== 2'b00 || req_rdata !== 16'h0 || fb.fb_sel_o !== 1'b0) begin errors++; $display("FAIL rst_stray_ack got ack=%b data=%h sel=%b want 00 0000 0", req_ack, req_rdata, fb.fb_sel_o); end
    req_sel = 2'b11;
    wait_sel(10, seen);
    checks++; if (!seen || grant !== 2'b01) begin errors++; $display("FAIL rst_ptr_restart got sel=%b grant=%b want 1 01", seen, grant); end
    fb.fb_ack_i = 1'b1;
    @(negedge clk);
    fb.fb_ack_i = 1'b0;
    req_sel = 2'b00;
    checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL rst_post_ack got %b want 01", req_ack); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int last;
    int acks;
    last = -1;
    acks = 0;
    req_sel = 2'b01;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (req_ack !== 2'b00) begin
        checks++; if (req_ack !== 2'b01 || req_err !== 1'b0) begin errors++; $display("FAIL b2b_ack_value[%0d] got ack=%b err=%b want 01 0", c, req_ack, req_err); end
        if (last >= 0) begin
          checks++; if (c - last !== 3) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 3", c, c - last); end
        end
        last = c;
        acks++;
      end
      fb.fb_ack_i = fb.fb_sel_o;
    end
    req_sel = 2'b00;
    fb.fb_ack_i = 1'b0;
    checks++; if (acks !== 6) begin errors++; $display("FAIL b2b_count got %0d want 6", acks); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_ni = 1'b1;
    req_sel = '0;
    req_wr = '0;
    req_mask = '0;
    req_addr = '0;
    req_wdata = '0;
    fb.fb_ack_i = 1'b0;
    fb.fb_data_i = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_contention();
    test_write_latch();
    test_timeout();
    test_reset_mid_issue();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
